rr_word_arbiter: RTL

- Round-robin scheduler that shares one 32-bit result bus between NREQ requesters.
- Each grant produces a fixed-length burst of tagged words.
- Every word comes from a package function returning a typedef'd ranged type (word_t).
- Sits between requester-side logic and a single downstream consumer with ready backpressure.

---
 rtl/rr_word_arbiter_pkg.sv | 21 ++
 rtl/rr_word_arbiter_pick.sv | 33 +++
 rtl/rr_word_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/rr_word_arbiter_pkg.sv
// rtl/rr_word_arbiter_pkg.sv - shared types and word tagging for the round-robin word arbiter
package arb_pkg;

  localparam int MAX_NREQ = 16;

  typedef logic [31:0] word_t;
  typedef logic [15:0] beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Requester index in the upper half-word, beat number in the lower half-word.
  function automatic word_t tag(input int unsigned i, input beat_t b);
    logic [15:0] w_idx;
    w_idx = i[15:0];
    return word_t'({w_idx, b});
  endfunction

endpackage

// File: rtl/rr_word_arbiter_pick.sv
// rtl/rr_word_arbiter_pick.sv - combinational round-robin winner search
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  assign any = |req;

  // Walk from ptr+1 with wrap; the first set request after the last owner wins.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_word_arbiter.sv
// rtl/rr_word_arbiter.sv - round-robin arbiter granting fixed-length tagged word bursts
module rr_word_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BURST_LEN = 4,
  parameter int WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    valid,
  input  logic                    ready,
  output logic [WIDTH-1:0]        data,
  output logic                    last
);

  localparam int    PW        = $clog2(NREQ);
  localparam beat_t LAST_BEAT = beat_t'(BURST_LEN - 1);

  if (WIDTH != $bits(word_t)) begin : g_bad_width
    $error("rr_word_arbiter: WIDTH must equal the word_t width");
  end
  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("rr_word_arbiter: NREQ out of range");
  end
  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_len
    $error("rr_word_arbiter: BURST_LEN out of range");
  end

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [NREQ-1:0] r_gnt;
  logic          r_valid;
  word_t         r_data;
  logic          r_last;
  beat_t         r_beat;

  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic [NREQ-1:0] w_gnt_next;
  beat_t           w_beat_inc;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_gnt_next = NREQ'(1) << w_winner;
  assign w_beat_inc = r_beat + 16'd1;

  // Requests are only looked at from IDLE, so every burst is followed by a bubble cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_owner <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= XFER;
            r_owner <= w_winner;
            r_gnt   <= w_gnt_next;
            r_valid <= 1'b1;
            r_beat  <= '0;
            r_data  <= tag(32'(w_winner), 16'd0);
            r_last  <= (LAST_BEAT == 16'd0);
          end
        end
        XFER: begin
          if (ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_ptr   <= r_owner;
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_beat  <= '0;
              r_data  <= '0;
            end else begin
              r_beat <= w_beat_inc;
              r_data <= tag(32'(r_owner), w_beat_inc);
              r_last <= (w_beat_inc == LAST_BEAT);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign valid = r_valid;
  assign data  = r_data;
  assign last  = r_last;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
  a_gnt_state  : assert property (@(posedge clk) disable iff (!rst_n)
                                  ((r_gnt != '0) == (r_state == XFER)) && ((r_state == XFER) == r_valid));
  a_gnt_owner  : assert property (@(posedge clk) disable iff (!rst_n) r_valid |-> r_gnt[r_owner]);

endmodule
